// File: rtl/divider_down_counter_if.sv
// Control and status signals of the divider down-counter, bundled for the
// driving block (master) and the counter itself (slave).
interface divider_down_counter_if #(
  parameter int n = 8
);
  logic         Load;
  logic [n-1:0] Divisor;
  logic         Enable;
  logic         Stop;
  logic [n-1:0] Count;
  logic         Terminal;
  logic         ClkOut;
  logic         Ready;
  logic         Running;

  modport master (
    output Load, Divisor, Enable, Stop,
    input  Count, Terminal, ClkOut, Ready, Running
  );

  modport slave (
    input  Load, Divisor, Enable, Stop,
    output Count, Terminal, ClkOut, Ready, Running
  );
endinterface

// File: rtl/divider_down_counter.sv
// Programmable down-counting clock divider: Count runs Divisor..0, then pulses
// Terminal, toggles ClkOut and reloads, with one queued divisor for seamless changes.
module divider_down_counter #(
  parameter int n = 8
) (
  input  logic                  Clk,
  input  logic                  nReset,
  divider_down_counter_if.slave bus
);

  localparam logic [0:0]   S_IDLE = 1'b0;
  localparam logic [0:0]   S_RUN  = 1'b1;
  localparam logic [n-1:0] ONE    = {{(n-1){1'b0}}, 1'b1};

  logic [0:0]   r_state;
  logic [n-1:0] r_count;
  logic [n-1:0] r_div;
  logic [n-1:0] r_pend;
  logic         r_pend_valid;
  logic         r_terminal;
  logic         r_clkout;

  logic [0:0]   w_state_next;
  logic [n-1:0] w_count_next;
  logic [n-1:0] w_div_next;
  logic [n-1:0] w_pend_next;
  logic         w_pend_valid_next;
  logic         w_terminal_next;
  logic         w_clkout_next;
  logic [n-1:0] w_reload;
  logic         w_at_terminal;

  // A Load arriving on the terminal cycle takes effect immediately, ahead of any queued value.
  assign w_reload      = bus.Load ? bus.Divisor : (r_pend_valid ? r_pend : r_div);
  assign w_at_terminal = (r_state == S_RUN) && bus.Enable && (r_count == '0);

  always_comb begin
    w_state_next      = r_state;
    w_count_next      = r_count;
    w_div_next        = r_div;
    w_pend_next       = r_pend;
    w_pend_valid_next = r_pend_valid;
    w_terminal_next   = 1'b0;
    w_clkout_next     = r_clkout;

    if (bus.Stop) begin
      w_state_next      = S_IDLE;
      w_count_next      = '0;
      w_clkout_next     = 1'b0;
      w_pend_valid_next = 1'b0;
    end else if (r_state == S_IDLE) begin
      // Starting from IDLE is a load request, independent of the count enable.
      if (bus.Load && (bus.Divisor != '0)) begin
        w_div_next   = bus.Divisor;
        w_count_next = bus.Divisor;
        w_state_next = S_RUN;
      end
    end else if (w_at_terminal) begin
      w_terminal_next   = 1'b1;
      w_clkout_next     = ~r_clkout;
      w_div_next        = w_reload;
      w_pend_valid_next = 1'b0;
      if (w_reload == '0) begin
        w_state_next = S_IDLE;
        w_count_next = '0;
      end else begin
        w_count_next = w_reload;
      end
    end else begin
      if (bus.Enable) begin
        w_count_next = r_count - ONE;
      end
      if (bus.Load) begin
        w_pend_next       = bus.Divisor;
        w_pend_valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_div        <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_terminal   <= 1'b0;
      r_clkout     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_count      <= w_count_next;
      r_div        <= w_div_next;
      r_pend       <= w_pend_next;
      r_pend_valid <= w_pend_valid_next;
      r_terminal   <= w_terminal_next;
      r_clkout     <= w_clkout_next;
    end
  end

  assign bus.Count    = r_count;
  assign bus.Terminal = r_terminal;
  assign bus.ClkOut   = r_clkout;
  assign bus.Ready    = ~r_pend_valid;
  assign bus.Running  = (r_state == S_RUN);

endmodule

// File: tb/tb_divider_down_counter.sv
// Bench for divider_down_counter: vector table, directed corner sequences,
// then random traffic compared against a period/phase reference model.
module tb_divider_down_counter;

  logic Clk;
  logic nReset;
  int   errors = 0;
  int   checks = 0;

  divider_down_counter_if #(.n(8)) bus ();

  divider_down_counter #(.n(8)) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .bus    (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    bit         load;
    logic [7:0] div;
    bit         en;
    bit         stop;
    logic [7:0] c;
    bit         t;
    bit         k;
    bit         r;
    bit         u;
  } vec_t;

  vec_t tbl [17];

  // Reference model: a period of (reload+1) enabled cycles, tracked by phase.
  bit m_run;
  int m_period;
  int m_phase;
  int m_base;
  int m_pend;
  bit m_pv;
  bit m_term;
  bit m_clk;

  task automatic model_reset();
    m_run = 0; m_period = 1; m_phase = 0; m_base = 0;
    m_pend = 0; m_pv = 0; m_term = 0; m_clk = 0;
  endtask

  task automatic model_step(input bit l, input int d, input bit e, input bit s);
    int nxt;
    m_term = 0;
    if (s) begin
      m_run = 0; m_clk = 0; m_pv = 0;
      return;
    end
    if (!m_run) begin
      if (l && d != 0) begin
        m_base = d; m_period = d + 1; m_phase = 0; m_run = 1;
      end
      return;
    end
    if (e) begin
      if (m_phase == m_period - 1) begin
        m_term = 1;
        m_clk  = !m_clk;
        nxt    = l ? d : (m_pv ? m_pend : m_base);
        m_base = nxt;
        m_pv   = 0;
        if (nxt == 0) m_run = 0;
        else begin
          m_period = nxt + 1;
          m_phase  = 0;
        end
        return;
      end
      m_phase++;
    end
    if (l) begin
      m_pend = d;
      m_pv   = 1;
    end
  endtask

  task automatic cmp(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", nm, f, act, exp);
    end
  endtask

  task automatic chk(input string nm, input int ec, input bit et, input bit ek, input bit er, input bit eu);
    cmp(nm, "Count",    32'(bus.Count),    32'(ec));
    cmp(nm, "Terminal", 32'(bus.Terminal), 32'(et));
    cmp(nm, "ClkOut",   32'(bus.ClkOut),   32'(ek));
    cmp(nm, "Ready",    32'(bus.Ready),    32'(er));
    cmp(nm, "Running",  32'(bus.Running),  32'(eu));
  endtask

  // Called at a falling edge: drive, let one rising edge pass, return at the next falling edge.
  task automatic tick(input bit l, input logic [7:0] d, input bit e, input bit s);
    bus.Load = l; bus.Divisor = d; bus.Enable = e; bus.Stop = s;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_reset(input string nm);
    bus.Load = 0; bus.Divisor = 0; bus.Enable = 0; bus.Stop = 0;
    @(negedge Clk);
    nReset = 1'b0;
    #1;
    chk(nm, 0, 0, 0, 1, 0);
    @(negedge Clk);
    nReset = 1'b1;
  endtask

  initial begin
    bit         l, e, s;
    logic [7:0] d;

    nReset = 1'b0;
    bus.Load = 0; bus.Divisor = 0; bus.Enable = 0; bus.Stop = 0;

    tbl[0]  = '{1, 8'd3, 1, 0, 8'd3, 0, 0, 1, 1};
    tbl[1]  = '{0, 8'd0, 1, 0, 8'd2, 0, 0, 1, 1};
    tbl[2]  = '{0, 8'd0, 1, 0, 8'd1, 0, 0, 1, 1};
    tbl[3]  = '{0, 8'd0, 1, 0, 8'd0, 0, 0, 1, 1};
    tbl[4]  = '{0, 8'd0, 1, 0, 8'd3, 1, 1, 1, 1};
    tbl[5]  = '{0, 8'd0, 1, 0, 8'd2, 0, 1, 1, 1};
    tbl[6]  = '{0, 8'd0, 1, 0, 8'd1, 0, 1, 1, 1};
    tbl[7]  = '{0, 8'd0, 1, 0, 8'd0, 0, 1, 1, 1};
    tbl[8]  = '{0, 8'd0, 1, 0, 8'd3, 1, 0, 1, 1};
    tbl[9]  = '{0, 8'd0, 1, 0, 8'd2, 0, 0, 1, 1};
    tbl[10] = '{0, 8'd0, 1, 0, 8'd1, 0, 0, 1, 1};
    tbl[11] = '{0, 8'd0, 1, 0, 8'd0, 0, 0, 1, 1};
    tbl[12] = '{1, 8'd7, 1, 0, 8'd7, 1, 1, 1, 1};
    tbl[13] = '{0, 8'd0, 1, 0, 8'd6, 0, 1, 1, 1};
    tbl[14] = '{1, 8'd9, 1, 1, 8'd0, 0, 0, 1, 0};
    tbl[15] = '{1, 8'd0, 1, 0, 8'd0, 0, 0, 1, 0};
    tbl[16] = '{1, 8'd2, 1, 0, 8'd2, 0, 0, 1, 1};

    do_reset("reset");
    for (int i = 0; i < 17; i++) begin
      tick(tbl[i].load, tbl[i].div, tbl[i].en, tbl[i].stop);
      $display("vec %0d load=%0d div=%0d en=%0d stop=%0d -> count=%0d term=%0d clkout=%0d ready=%0d running=%0d",
               i, tbl[i].load, tbl[i].div, tbl[i].en, tbl[i].stop,
               bus.Count, bus.Terminal, bus.ClkOut, bus.Ready, bus.Running);
      chk($sformatf("vec%0d", i), int'(tbl[i].c), tbl[i].t, tbl[i].k, tbl[i].r, tbl[i].u);
    end

    // Divisor change queued mid-count, applied at the next terminal.
    do_reset("reset_pend");
    tick(1, 8'd5, 1, 0); chk("pend_load5", 5, 0, 0, 1, 1);
    tick(0, 8'd0, 1, 0); chk("pend_c4", 4, 0, 0, 1, 1);
    tick(0, 8'd0, 1, 0); chk("pend_c3", 3, 0, 0, 1, 1);
    tick(1, 8'd2, 1, 0); chk("pend_queue2", 2, 0, 0, 0, 1);
    tick(0, 8'd0, 1, 0); chk("pend_c1", 1, 0, 0, 0, 1);
    tick(0, 8'd0, 1, 0); chk("pend_c0", 0, 0, 0, 0, 1);
    tick(0, 8'd0, 1, 0); chk("pend_term", 2, 1, 1, 1, 1);
    tick(0, 8'd0, 1, 0); chk("pend_p3_c1", 1, 0, 1, 1, 1);
    tick(0, 8'd0, 1, 0); chk("pend_p3_c0", 0, 0, 1, 1, 1);
    tick(0, 8'd0, 1, 0); chk("pend_p3_term", 2, 1, 0, 1, 1);
    $display("seq pending-divisor done");

    // Enable held low at Count=2, with a Load captured while disabled.
    do_reset("reset_hold");
    tick(1, 8'd4, 1, 0); chk("hold_load4", 4, 0, 0, 1, 1);
    tick(0, 8'd0, 1, 0); chk("hold_c3", 3, 0, 0, 1, 1);
    tick(0, 8'd0, 1, 0); chk("hold_c2", 2, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      tick(i == 5, 8'd6, 0, 0);
      chk($sformatf("hold_dis%0d", i), 2, 0, 0, (i < 5), 1);
    end
    tick(0, 8'd0, 1, 0); chk("hold_res_c1", 1, 0, 0, 0, 1);
    tick(0, 8'd0, 1, 0); chk("hold_res_c0", 0, 0, 0, 0, 1);
    tick(0, 8'd0, 1, 0); chk("hold_term6", 6, 1, 1, 1, 1);
    $display("seq enable-hold done");

    // Pending zero ends in IDLE; asynchronous reset mid-RUN discards the queue.
    do_reset("reset_zero");
    tick(1, 8'd2, 1, 0); chk("zero_load2", 2, 0, 0, 1, 1);
    tick(1, 8'd0, 1, 0); chk("zero_queue0", 1, 0, 0, 0, 1);
    tick(0, 8'd0, 1, 0); chk("zero_c0", 0, 0, 0, 0, 1);
    tick(0, 8'd0, 1, 0); chk("zero_term", 0, 1, 1, 1, 0);
    tick(0, 8'd0, 1, 0); chk("zero_idle", 0, 0, 1, 1, 0);
    tick(1, 8'd5, 1, 0); chk("arst_load5", 5, 0, 1, 1, 1);
    tick(0, 8'd0, 1, 0); chk("arst_c4", 4, 0, 1, 1, 1);
    tick(1, 8'd3, 1, 0); chk("arst_queue3", 3, 0, 1, 0, 1);
    bus.Load = 0; bus.Enable = 1;
    #2;
    nReset = 1'b0;
    #1;
    chk("arst_async", 0, 0, 0, 1, 0);
    @(negedge Clk);
    nReset = 1'b1;
    tick(0, 8'd0, 1, 0); chk("arst_after", 0, 0, 0, 1, 0);
    tick(1, 8'd1, 1, 0); chk("arst_load1", 1, 0, 0, 1, 1);
    tick(0, 8'd0, 1, 0); chk("arst_c0", 0, 0, 0, 1, 1);
    tick(0, 8'd0, 1, 0); chk("arst_reload1", 1, 1, 1, 1, 1);
    $display("seq zero-divisor/async-reset done");

    // Random traffic against the reference model.
    do_reset("reset_rand");
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      l = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      e = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 59) == 0);
      tick(l, d, e, s);
      model_step(l, int'(d), e, s);
      chk($sformatf("rand%0d", i), m_run ? (m_period - 1 - m_phase) : 0,
          m_term, m_clk, !m_pv, m_run);
      if (i % 500 == 499)
        $display("rand batch ending at cycle %0d: errors so far %0d", i, errors);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divider_down_counter.md
DIVIDER_DOWN_COUNTER -- requirements
Module: divider_down_counter

Interface
REQ-001 SHALL have parameter: n, 8, width of counter, divisor and count output.
REQ-002 SHALL have port: Clk  input  1  system clock; all state changes on rising edge except reset.
REQ-003 SHALL have port: nReset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: Load  input  1  request to accept Divisor, sampled each Clk edge.
REQ-005 SHALL have port: Divisor  input  n  reload value; terminal period = Divisor+1 enabled cycles.
REQ-006 SHALL have port: Enable  input  1  count enable; low = hold all state.
REQ-007 SHALL have port: Stop  input  1  synchronous abort to IDLE.
REQ-008 SHALL have port: Count  output  n  current down-count value (registered).
REQ-009 SHALL have port: Terminal  output  1  one-cycle pulse, registered, at each terminal count.
REQ-010 SHALL have port: ClkOut  output  1  divided clock, toggles on each terminal count.
REQ-011 SHALL have port: Ready  output  1  high when no pending divisor is queued.
REQ-012 SHALL have port: Running  output  1  high in state RUN.

Function
REQ-013 SHALL implement two states, IDLE and RUN, plus internal registers DivReg (n), Pending (n), PendingValid (1).
REQ-014 SHALL, in IDLE with Load=1 and Divisor!=0: DivReg<=Divisor, Count<=Divisor, go RUN next edge.
REQ-015 SHALL, in IDLE with Load=1 and Divisor==0: ignore the request, remain IDLE, outputs unchanged.
REQ-016 SHALL, in RUN with Enable=1 and Count!=0: Count<=Count-1.
REQ-017 SHALL, in RUN with Enable=1 and Count==0: assert Terminal for exactly the next cycle, toggle ClkOut, reload Count.
REQ-018 SHALL reload from Pending (and copy Pending to DivReg, clear PendingValid) when PendingValid=1, else from DivReg.
REQ-019 SHALL, if the reload value is 0, complete the terminal pulse and ClkOut toggle, then enter IDLE with Count=0.
REQ-020 SHALL, in RUN with Load=1 on a cycle that is not a terminal reload: Pending<=Divisor, PendingValid<=1 (overwrites any earlier pending value).
REQ-021 SHALL, in RUN with Load=1 on the terminal reload cycle: bypass Pending, reload directly from Divisor, DivReg<=Divisor, PendingValid<=0.
REQ-022 SHALL, with Enable=0: hold Count, ClkOut, state; Terminal=0; Load still captured into Pending per REQ-020.
REQ-023 SHALL, on Stop=1 (any state): next edge Count=0, ClkOut=0, Terminal=0, PendingValid=0, state IDLE; Stop wins over Load and Enable.
REQ-024 SHALL drive Ready = !PendingValid and Running = (state==RUN), both registered.
REQ-025 SHALL yield, with constant Divisor D and Enable=1, Terminal period D+1 cycles and ClkOut period 2(D+1) with 50% duty.
REQ-026 SHALL perform Count arithmetic modulo 2^n with no underflow past 0 (0 always reloads).

Reset
REQ-027 SHALL on nReset=0 immediately set Count=0, DivReg=0, Pending=0, PendingValid=0, Terminal=0, ClkOut=0, state IDLE, Ready=1, Running=0.
REQ-028 SHALL resume operation on the first rising Clk edge after nReset deasserts; reset mid-RUN discards all pending state.

Verification
REQ-029 SHALL cover: reset, Load Divisor=3, Enable=1 -> Count 3,2,1,0,3...; Terminal every 4 cycles; ClkOut period 8 cycles.
REQ-030 SHALL cover: in RUN D=5, Load Divisor=2 mid-count -> Ready=0 until next terminal, then period becomes 3, Ready=1.
REQ-031 SHALL cover: Load Divisor=7 exactly on Count==0 cycle -> Count reloads 7 immediately, PendingValid stays 0.
REQ-032 SHALL cover: Enable low 10 cycles at Count=2 -> Count holds 2, no Terminal; resumes 1,0 after Enable high.
REQ-033 SHALL cover: Stop and Load asserted together in RUN -> IDLE, Count=0, ClkOut=0, Ready=1, Running=0.
REQ-034 SHALL cover: pending Divisor=0 and Load Divisor=0 in IDLE -> former ends in IDLE after one Terminal; latter ignored; nReset pulse mid-RUN clears all outputs asynchronously.
